// File: rtl/key_pkg.sv
// Shared definitions for the key entry decoder: ASCII byte constants,
// the entry FSM state encoding and a case-folding helper for letters.
package key_pkg;

  localparam logic [7:0] ASC_BS   = 8'h08;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_ESC  = 8'h1B;
  localparam logic [7:0] ASC_DEL  = 8'h7F;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_5    = 8'h35;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_UC_A = 8'h41;
  localparam logic [7:0] ASC_UC_L = 8'h4C;
  localparam logic [7:0] ASC_UC_N = 8'h4E;
  localparam logic [7:0] ASC_UC_S = 8'h53;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WAIT_CR = 2'd2
  } ent_state_e;

  // Clearing bit 5 maps 'a'..'z' onto 'A'..'Z'. Only used for equality
  // against upper-case letters, where the only other byte that folds onto
  // the same code is the lower-case letter itself.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return c & 8'hDF;
  endfunction

endpackage

// File: rtl/key_entry_decoder_ascii_key_class.sv
// ascii_key_class: purely combinational classifier for one ASCII byte.
// Ports:
//   char_i      ASCII byte
//   is_digit_o  '0'..'9'
//   is_0to5_o   '0'..'5'
//   digit_o     BCD value of the digit (meaningful only when is_digit_o)
//   is_esc_o    ESC
//   is_cr_o     carriage return
//   is_bs_o     backspace or DEL
//   is_a_o, is_l_o, is_s_o, is_n_o   letter, either case
module ascii_key_class
  import key_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_0to5_o,
  output logic [3:0] digit_o,
  output logic       is_esc_o,
  output logic       is_cr_o,
  output logic       is_bs_o,
  output logic       is_a_o,
  output logic       is_l_o,
  output logic       is_s_o,
  output logic       is_n_o
);

  logic [7:0] folded;

  assign folded     = fold_case(char_i);
  assign is_digit_o = (char_i >= ASC_0) && (char_i <= ASC_9);
  assign is_0to5_o  = (char_i >= ASC_0) && (char_i <= ASC_5);
  // '0'..'9' are 0x30..0x39, so the low nibble is the BCD value.
  assign digit_o    = char_i[3:0];
  assign is_esc_o   = (char_i == ASC_ESC);
  assign is_cr_o    = (char_i == ASC_CR);
  assign is_bs_o    = (char_i == ASC_BS) || (char_i == ASC_DEL);
  assign is_a_o     = (folded == ASC_UC_A);
  assign is_l_o     = (folded == ASC_UC_L);
  assign is_s_o     = (folded == ASC_UC_S);
  assign is_n_o     = (folded == ASC_UC_N);

endmodule

// File: rtl/key_entry_decoder.sv
// key_entry_decoder: classifies UART RX bytes, emits command strobes in IDLE
// and collects a multi-digit BCD time entry opened by 'A'/'L', committed by
// CR, aborted by ESC or idle timeout, with backspace editing.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   charData        ASCII byte, qualified by charDataValid
//   det_start/stop/ledSel  1-cycle strobes for S / CR / N while idle
//   ent_busy        entry in progress
//   ent_count       digits currently held in the working register
//   ent_valid       1-cycle strobe: entry committed
//   ent_target      target of last commit (0 load, 1 alarm)
//   ent_digits      last committed digits, first-entered in the MS nibble
//   ent_err         1-cycle strobe: byte rejected
//   ent_abort       1-cycle strobe: entry abandoned
// All outputs are registered; response appears one cycle after the byte.
module key_entry_decoder
  import key_pkg::*;
#(
  parameter int                    NUM_DIGITS   = 4,
  parameter logic [NUM_DIGITS-1:0] LIMIT05_MASK = 4'b1010,
  parameter int                    TIMEOUT_CYC  = 0,
  parameter int                    TO_W         = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              charData,
  input  logic                    charDataValid,
  output logic                    det_start,
  output logic                    det_stop,
  output logic                    det_ledSel,
  output logic                    ent_busy,
  output logic [3:0]              ent_count,
  output logic                    ent_valid,
  output logic                    ent_target,
  output logic [4*NUM_DIGITS-1:0] ent_digits,
  output logic                    ent_err,
  output logic                    ent_abort
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [3:0] FULL = 4'(NUM_DIGITS);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

  logic       is_digit, is_0to5, is_esc, is_cr, is_bs, is_a, is_l, is_s, is_n;
  logic [3:0] digit;

  ascii_key_class u_class (
    .char_i     (charData),
    .is_digit_o (is_digit),
    .is_0to5_o  (is_0to5),
    .digit_o    (digit),
    .is_esc_o   (is_esc),
    .is_cr_o    (is_cr),
    .is_bs_o    (is_bs),
    .is_a_o     (is_a),
    .is_l_o     (is_l),
    .is_s_o     (is_s),
    .is_n_o     (is_n)
  );

  ent_state_e      state_q, state_d;
  logic [W-1:0]    work_q, work_d, digits_q, digits_d;
  logic [3:0]      count_q, count_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            pend_q, pend_d, target_q, target_d;
  logic            start_q, start_d, stop_q, stop_d, led_q, led_d, busy_q, busy_d;
  logic            valid_q, valid_d, err_q, err_d, abort_q, abort_d;
  logic            lim_here, digit_ok, timeout_hit;

  // The mask is indexed by remaining positions: the next digit entered lands
  // at position NUM_DIGITS-1-count once the entry is complete.
  always_comb begin
    lim_here = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (NUM_DIGITS - 1 - i == int'(count_q)) lim_here = LIMIT05_MASK[i];
    end
  end

  assign digit_ok    = is_digit && (!lim_here || is_0to5);
  assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q != ST_IDLE) && (to_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    pend_d   = pend_q;
    target_d = target_q;
    digits_d = digits_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    led_d    = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    abort_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (charDataValid) begin
          if (is_s)             start_d = 1'b1;
          else if (is_cr)       stop_d  = 1'b1;
          else if (is_n)        led_d   = 1'b1;
          else if (is_a || is_l) begin
            pend_d  = is_a;
            work_d  = '0;
            count_d = '0;
            state_d = ST_COLLECT;
          end
        end
      end

      ST_COLLECT, ST_WAIT_CR: begin
        if (charDataValid) begin
          if (is_esc) begin
            abort_d = 1'b1;
            count_d = '0;
            state_d = ST_IDLE;
          end else if (is_bs) begin
            if (count_q != 4'd0) begin
              work_d  = work_q >> 4;
              count_d = count_q - 4'd1;
              state_d = ST_COLLECT;
            end else begin
              err_d = 1'b1;
            end
          end else if (state_q == ST_WAIT_CR && is_cr) begin
            valid_d  = 1'b1;
            digits_d = work_q;
            target_d = pend_q;
            count_d  = '0;
            state_d  = ST_IDLE;
          end else if (state_q == ST_COLLECT && digit_ok) begin
            work_d  = (work_q << 4) | W'(digit);
            count_d = count_q + 4'd1;
            if (count_q + 4'd1 == FULL) state_d = ST_WAIT_CR;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    if (TIMEOUT_CYC == 0 || charDataValid || state_q == ST_IDLE) to_d = '0;
    else                                                         to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      to_q     <= '0;
      pend_q   <= 1'b0;
      target_q <= 1'b0;
      digits_q <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      to_q     <= to_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      digits_q <= digits_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  assign det_start  = start_q;
  assign det_stop   = stop_q;
  assign det_ledSel = led_q;
  assign ent_busy   = busy_q;
  assign ent_count  = count_q;
  assign ent_valid  = valid_q;
  assign ent_target = target_q;
  assign ent_digits = digits_q;
  assign ent_err    = err_q;
  assign ent_abort  = abort_q;

endmodule

// File: tb/tb_key_entry_decoder.sv
module tb_key_entry_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] charData = 8'h00;
  logic       vld = 1'b0;
  logic       sel6 = 1'b0;
  logic       vld4, vld6;

  assign vld4 = vld & ~sel6;
  assign vld6 = vld & sel6;

  always #5 clk = ~clk;

  logic        start4, stop4, led4, busy4, valid4, tgt4, err4, abort4;
  logic [3:0]  cnt4;
  logic [15:0] dig4;
  logic        start6, stop6, led6, busy6, valid6, tgt6, err6, abort6;
  logic [3:0]  cnt6;
  logic [23:0] dig6;

  key_entry_decoder #(.NUM_DIGITS(4), .LIMIT05_MASK(4'b1010), .TIMEOUT_CYC(100), .TO_W(24)) dut4 (
    .clk(clk), .rst(rst), .charData(charData), .charDataValid(vld4),
    .det_start(start4), .det_stop(stop4), .det_ledSel(led4), .ent_busy(busy4),
    .ent_count(cnt4), .ent_valid(valid4), .ent_target(tgt4), .ent_digits(dig4),
    .ent_err(err4), .ent_abort(abort4)
  );

  key_entry_decoder #(.NUM_DIGITS(6), .LIMIT05_MASK(6'b101010), .TIMEOUT_CYC(100), .TO_W(24)) dut6 (
    .clk(clk), .rst(rst), .charData(charData), .charDataValid(vld6),
    .det_start(start6), .det_stop(stop6), .det_ledSel(led6), .ent_busy(busy6),
    .ent_count(cnt6), .ent_valid(valid6), .ent_target(tgt6), .ent_digits(dig6),
    .ent_err(err6), .ent_abort(abort6)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the edge
  // that captured the byte, so the registered response is visible.
  task automatic send(input logic [7:0] b);
    charData = b;
    vld      = 1'b1;
    @(posedge clk);
    #1;
    vld      = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Send a byte to the 4-digit instance and check the three entry strobes.
  task automatic send_e(input logic [7:0] b, input logic e_err, input logic e_valid, input logic e_abort);
    send(b);
    check($sformatf("err@%02h", b), {31'd0, err4}, {31'd0, e_err});
    check($sformatf("valid@%02h", b), {31'd0, valid4}, {31'd0, e_valid});
    check($sformatf("abort@%02h", b), {31'd0, abort4}, {31'd0, e_abort});
  endtask

  task automatic check_all_zero4(input string tag);
    check({tag, "_det"}, {29'd0, start4, stop4, led4}, 32'd0);
    check({tag, "_ctl"}, {28'd0, busy4, valid4, err4, abort4}, 32'd0);
    check({tag, "_cnt"}, {28'd0, cnt4}, 32'd0);
    check({tag, "_dig"}, {16'd0, dig4}, 32'd0);
    check({tag, "_tgt"}, {31'd0, tgt4}, 32'd0);
  endtask

  int seen;
  int at_cyc;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    check_all_zero4("rst");
    check("rst6_dig", {8'd0, dig6}, 32'd0);
    #9 rst = 1'b0;
    idle();

    // Test 1: L1234 CR
    send_e("L", 1'b0, 1'b0, 1'b0);
    check("t1_busyL", {31'd0, busy4}, 32'd1);
    send_e("1", 1'b0, 1'b0, 1'b0);
    send_e("2", 1'b0, 1'b0, 1'b0);
    send_e("3", 1'b0, 1'b0, 1'b0);
    send_e("4", 1'b0, 1'b0, 1'b0);
    check("t1_cnt", {28'd0, cnt4}, 32'd4);
    check("t1_busy4", {31'd0, busy4}, 32'd1);
    send_e(8'h0D, 1'b0, 1'b1, 1'b0);
    check("t1_dig", {16'd0, dig4}, 32'h1234);
    check("t1_tgt", {31'd0, tgt4}, 32'd0);
    check("t1_busyCR", {31'd0, busy4}, 32'd0);
    check("t1_nostop", {31'd0, stop4}, 32'd0);
    idle();
    check("t1_vpulse", {31'd0, valid4}, 32'd0);

    // Test 2: first position limited to 0-5, third position limited too
    send_e("A", 1'b0, 1'b0, 1'b0);
    send_e("7", 1'b1, 1'b0, 1'b0);
    check("t2_cnt7", {28'd0, cnt4}, 32'd0);
    send_e("0", 1'b0, 1'b0, 1'b0);
    send_e("5", 1'b0, 1'b0, 1'b0);
    send_e("5", 1'b0, 1'b0, 1'b0);
    send_e("9", 1'b0, 1'b0, 1'b0);
    send_e(8'h0D, 1'b0, 1'b1, 1'b0);
    check("t2_dig", {16'd0, dig4}, 32'h0559);
    check("t2_tgt", {31'd0, tgt4}, 32'd1);
    send_e("A", 1'b0, 1'b0, 1'b0);
    send_e("5", 1'b0, 1'b0, 1'b0);
    send_e("9", 1'b0, 1'b0, 1'b0);
    send_e("6", 1'b1, 1'b0, 1'b0);
    check("t2_cnt6", {28'd0, cnt4}, 32'd2);
    send_e("S", 1'b1, 1'b0, 1'b0);
    check("t2_nostart", {31'd0, start4}, 32'd0);
    send_e(8'h1B, 1'b0, 1'b0, 1'b1);

    // Test 3: backspace editing, BS at count 0, short entry
    send_e("a", 1'b0, 1'b0, 1'b0);
    send_e("1", 1'b0, 1'b0, 1'b0);
    send_e("2", 1'b0, 1'b0, 1'b0);
    send_e(8'h08, 1'b0, 1'b0, 1'b0);
    check("t3_cntbs", {28'd0, cnt4}, 32'd1);
    send_e("3", 1'b0, 1'b0, 1'b0);
    send_e("4", 1'b0, 1'b0, 1'b0);
    send_e("5", 1'b0, 1'b0, 1'b0);
    send_e(8'h7F, 1'b0, 1'b0, 1'b0);
    check("t3_cntdel", {28'd0, cnt4}, 32'd3);
    send_e("5", 1'b0, 1'b0, 1'b0);
    send_e("7", 1'b1, 1'b0, 1'b0);
    send_e(8'h0D, 1'b0, 1'b1, 1'b0);
    check("t3_dig", {16'd0, dig4}, 32'h1345);
    check("t3_tgt", {31'd0, tgt4}, 32'd1);
    send_e("a", 1'b0, 1'b0, 1'b0);
    send_e(8'h08, 1'b1, 1'b0, 1'b0);
    send_e("1", 1'b0, 1'b0, 1'b0);
    send_e("2", 1'b0, 1'b0, 1'b0);
    send_e("3", 1'b0, 1'b0, 1'b0);
    send_e(8'h0D, 1'b1, 1'b0, 1'b0);
    check("t3_shortbusy", {31'd0, busy4}, 32'd1);
    send_e(8'h1B, 1'b0, 1'b0, 1'b1);
    check("t3_esccnt", {28'd0, cnt4}, 32'd0);

    // Test 4: ESC keeps committed digits, timeout aborts exactly once
    send_e("l", 1'b0, 1'b0, 1'b0);
    send_e("1", 1'b0, 1'b0, 1'b0);
    send_e("2", 1'b0, 1'b0, 1'b0);
    send_e(8'h1B, 1'b0, 1'b0, 1'b1);
    check("t4_dig", {16'd0, dig4}, 32'h1345);
    check("t4_tgt", {31'd0, tgt4}, 32'd1);
    check("t4_busy", {31'd0, busy4}, 32'd0);
    send_e("l", 1'b0, 1'b0, 1'b0);
    send_e("1", 1'b0, 1'b0, 1'b0);
    seen   = 0;
    at_cyc = 0;
    for (int i = 1; i <= 110; i++) begin
      idle();
      if (abort4) begin
        seen++;
        at_cyc = i;
      end
    end
    check("t4_to_count", seen, 32'd1);
    check("t4_to_cycle", at_cyc, 32'd100);
    check("t4_to_busy", {31'd0, busy4}, 32'd0);
    check("t4_to_dig", {16'd0, dig4}, 32'h1345);

    // Test 5: IDLE command strobes; other bytes silently ignored
    send("s");
    check("t5_s", {29'd0, start4, stop4, led4}, 32'b100);
    send(8'h0D);
    check("t5_cr", {29'd0, start4, stop4, led4}, 32'b010);
    send("N");
    check("t5_n", {29'd0, start4, stop4, led4}, 32'b001);
    send("@");
    check("t5_at", {28'd0, start4, stop4, led4, err4}, 32'd0);
    send("9");
    check("t5_9", {28'd0, start4, stop4, led4, err4}, 32'd0);
    send(8'h1B);
    check("t5_esc", {29'd0, err4, abort4, busy4}, 32'd0);
    idle();
    check("t5_clear", {29'd0, start4, stop4, led4}, 32'd0);

    // Test 6: async reset in WAIT_CR, then 6-digit instance
    send_e("L", 1'b0, 1'b0, 1'b0);
    send_e("1", 1'b0, 1'b0, 1'b0);
    send_e("2", 1'b0, 1'b0, 1'b0);
    send_e("3", 1'b0, 1'b0, 1'b0);
    send_e("4", 1'b0, 1'b0, 1'b0);
    check("t6_pre_busy", {31'd0, busy4}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_all_zero4("t6_rst");
    #5 rst = 1'b0;
    idle();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (valid4 || busy4) seen++;
    end
    check("t6_noval", seen, 32'd0);
    send(8'h0D);
    check("t6_cr_stop", {30'd0, stop4, valid4}, 32'b10);

    sel6 = 1'b1;
    send("L");
    check("t6_busy6", {31'd0, busy6}, 32'd1);
    send("1");
    send("2");
    send("3");
    send("4");
    send("5");
    send("6");
    check("t6_cnt6", {28'd0, cnt6}, 32'd6);
    send(8'h0D);
    check("t6_valid6", {31'd0, valid6}, 32'd1);
    check("t6_dig6", {8'd0, dig6}, 32'h123456);
    check("t6_tgt6", {31'd0, tgt6}, 32'd0);
    check("t6_dut4_quiet", {16'd0, dig4}, 32'h0000);
    sel6 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
